// File: rtl/fifo_async_read_ctrl_if.sv
// Read-side bus of the asynchronous FIFO: pop request, synchronised write
// pointer, RAM read port, pointers, flags and registered read data.
//   slave  : the read controller (fifo_async_read_ctrl)
//   master : the consumer / RAM / synchroniser side
// Signals:
//   read_in         pop request
//   wptr_g_sync_in  Gray write pointer, already in the read clock domain
//   rdata_mem_in    RAM read data, combinational from raddr_out
//   raddr_out       RAM read address
//   rptr_b_out      binary read pointer (wrap bit included)
//   rptr_g_out      Gray read pointer for the write-side synchroniser
//   empty_out       no word available
//   aempty_out      fill level at or below AEMPTY_LEVEL
//   rdata_out       registered read data
//   rvalid_out      rdata_out holds valid data
interface fifo_async_read_ctrl_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PTR_WIDTH = 4
);
  logic                 read_in;
  logic [PTR_WIDTH-1:0] wptr_g_sync_in;
  logic [WIDTH-1:0]     rdata_mem_in;
  logic [PTR_WIDTH-2:0] raddr_out;
  logic [PTR_WIDTH-1:0] rptr_b_out;
  logic [PTR_WIDTH-1:0] rptr_g_out;
  logic                 empty_out;
  logic                 aempty_out;
  logic [WIDTH-1:0]     rdata_out;
  logic                 rvalid_out;

  modport slave (
    input  read_in, wptr_g_sync_in, rdata_mem_in,
    output raddr_out, rptr_b_out, rptr_g_out, empty_out, aempty_out,
           rdata_out, rvalid_out
  );

  modport master (
    output read_in, wptr_g_sync_in, rdata_mem_in,
    input  raddr_out, rptr_b_out, rptr_g_out, empty_out, aempty_out,
           rdata_out, rvalid_out
  );
endinterface

// File: rtl/fifo_async_read_ctrl.sv
// Read-side controller of the asynchronous FIFO (read clock domain only).
// Owns the binary and Gray read pointers, derives empty / almost-empty from
// the synchronised Gray write pointer, drives the RAM read address and
// registers the read data.
// Ports:
//   read_clk  read-domain clock, rising edge
//   nrst_in   asynchronous active-low reset
//   rd        fifo_async_read_ctrl_if.slave (pop, pointers, flags, data)
// Configuration:
//   FIFO_ASYNC_RD_FWFT_EN  defined   -> first-word-fall-through output
//                          undefined -> standard 1-cycle read latency
module fifo_async_read_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned PTR_WIDTH    = 4,
  parameter int unsigned AEMPTY_LEVEL = 1
) (
  input logic                  read_clk,
  input logic                  nrst_in,
  fifo_async_read_ctrl_if.slave rd
);

  typedef logic [PTR_WIDTH-1:0] ptr_t;
  localparam ptr_t AEMPTY_LVL = ptr_t'(AEMPTY_LEVEL);

  ptr_t             rptr_b_q, rptr_b_d;
  ptr_t             rptr_g_q, rptr_g_d;
  logic             mem_empty_q, mem_empty_d;
  logic             aempty_q, aempty_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             rvalid_q, rvalid_d;

  logic             advance;
  ptr_t             wptr_b_sync;
  ptr_t             fill;

  always_comb begin
    advance     = 1'b0;
    rdata_d     = rdata_q;
    rvalid_d    = rvalid_q;
    wptr_b_sync = '0;

`ifdef FIFO_ASYNC_RD_FWFT_EN
    // Prefetch into the output register whenever it is free or being popped.
    advance = ~mem_empty_q & (~rvalid_q | rd.read_in);
    if (advance) begin
      rdata_d  = rd.rdata_mem_in;
      rvalid_d = 1'b1;
    end else if (rd.read_in) begin
      rvalid_d = 1'b0;
    end
`else
    advance = rd.read_in & ~mem_empty_q;
    rvalid_d = advance;
    if (advance) begin
      rdata_d = rd.rdata_mem_in;
    end
`endif

    rptr_b_d = rptr_b_q + {{(PTR_WIDTH-1){1'b0}}, advance};
    rptr_g_d = (rptr_b_d >> 1) ^ rptr_b_d;

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    for (int unsigned i = 0; i < PTR_WIDTH; i++) begin
      wptr_b_sync[i] = ^(rd.wptr_g_sync_in >> i);
    end

    // Flags use the post-update pointer so the last pop sets empty at once.
    mem_empty_d = (rptr_g_d == rd.wptr_g_sync_in);
    fill        = wptr_b_sync - rptr_b_d;
    aempty_d    = (fill <= AEMPTY_LVL);
  end

  always_ff @(posedge read_clk or negedge nrst_in) begin
    if (!nrst_in) begin
      rptr_b_q    <= '0;
      rptr_g_q    <= '0;
      mem_empty_q <= 1'b1;
      aempty_q    <= 1'b1;
      rdata_q     <= '0;
      rvalid_q    <= 1'b0;
    end else begin
      rptr_b_q    <= rptr_b_d;
      rptr_g_q    <= rptr_g_d;
      mem_empty_q <= mem_empty_d;
      aempty_q    <= aempty_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
    end
  end

  assign rd.raddr_out  = rptr_b_q[PTR_WIDTH-2:0];
  assign rd.rptr_b_out = rptr_b_q;
  assign rd.rptr_g_out = rptr_g_q;
  assign rd.aempty_out = aempty_q;
  assign rd.rdata_out  = rdata_q;
  assign rd.rvalid_out = rvalid_q;
`ifdef FIFO_ASYNC_RD_FWFT_EN
  assign rd.empty_out  = ~rvalid_q;
`else
  assign rd.empty_out  = mem_empty_q;
`endif

endmodule

// File: tb/tb_fifo_async_read_ctrl.sv
module tb_fifo_async_read_ctrl;

  logic       clk;
  logic       nrst;
  logic [7:0] mem [8];
  int         n_checks;
  int         n_errors;

  fifo_async_read_ctrl_if #(.WIDTH(8), .PTR_WIDTH(4)) rd ();

  fifo_async_read_ctrl #(
    .WIDTH(8),
    .PTR_WIDTH(4),
    .AEMPTY_LEVEL(2)
  ) dut (
    .read_clk(clk),
    .nrst_in (nrst),
    .rd      (rd)
  );

  assign rd.rdata_mem_in = mem[rd.raddr_out];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rptr_b"}, rd.rptr_b_out, 0);
    check({tag, "_rptr_g"}, rd.rptr_g_out, 0);
    check({tag, "_raddr"},  rd.raddr_out,  0);
    check({tag, "_empty"},  rd.empty_out,  1);
    check({tag, "_aempty"}, rd.aempty_out, 1);
    check({tag, "_rdata"},  rd.rdata_out,  0);
    check({tag, "_rvalid"}, rd.rvalid_out, 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i);
    rd.read_in        = 1'b0;
    rd.wptr_g_sync_in = 4'b0000;
    nrst = 1'b1;
    #1 nrst = 1'b0;
    #1 check_reset("rst0");
    step();
    step();
    nrst = 1'b1;
    step();
    check("idle_empty", rd.empty_out, 1);

`ifdef FIFO_ASYNC_RD_FWFT_EN
    mem[0] = 8'hD0;
    mem[1] = 8'hD1;
    mem[2] = 8'hD2;
    rd.wptr_g_sync_in = 4'b0001;
    step();
    check("fw_lat1_rvalid", rd.rvalid_out, 0);
    step();
    check("fw_lat2_rvalid", rd.rvalid_out, 1);
    check("fw_lat2_rdata",  rd.rdata_out,  8'hD0);
    check("fw_lat2_empty",  rd.empty_out,  0);
    check("fw_lat2_rptr",   rd.rptr_b_out, 1);
    rd.read_in = 1'b1;
    step();
    rd.read_in = 1'b0;
    check("fw_pop_rvalid", rd.rvalid_out, 0);
    check("fw_pop_empty",  rd.empty_out,  1);
    check("fw_pop_rptr",   rd.rptr_b_out, 1);
    rd.wptr_g_sync_in = 4'b0010;
    step();
    check("fw_b_lat1_rvalid", rd.rvalid_out, 0);
    step();
    check("fw_b_rvalid", rd.rvalid_out, 1);
    check("fw_b_rdata",  rd.rdata_out,  8'hD1);
    check("fw_b_rptr",   rd.rptr_b_out, 2);
    rd.read_in = 1'b1;
    step();
    check("fw_b2_rdata",  rd.rdata_out,  8'hD2);
    check("fw_b2_rvalid", rd.rvalid_out, 1);
    check("fw_b2_rptr",   rd.rptr_b_out, 3);
    step();
    rd.read_in = 1'b0;
    check("fw_b3_rvalid", rd.rvalid_out, 0);
    check("fw_b3_empty",  rd.empty_out,  1);
    check("fw_b3_rptr",   rd.rptr_b_out, 3);
    check("fw_b3_rdata",  rd.rdata_out,  8'hD2);
`else
    // Standard read of three words (write pointer binary 3).
    rd.wptr_g_sync_in = 4'b0010;
    step();
    check("std_empty_drop", rd.empty_out,  0);
    check("std_aempty_f3",  rd.aempty_out, 0);
    check("std_rvalid_idle", rd.rvalid_out, 0);
    rd.read_in = 1'b1;
    step();
    check("std_r1_rdata",  rd.rdata_out,  8'hA0);
    check("std_r1_rvalid", rd.rvalid_out, 1);
    check("std_r1_rptr_b", rd.rptr_b_out, 1);
    check("std_r1_rptr_g", rd.rptr_g_out, 4'b0001);
    check("std_r1_empty",  rd.empty_out,  0);
    check("std_r1_aempty", rd.aempty_out, 1);
    step();
    check("std_r2_rdata",  rd.rdata_out,  8'hA1);
    check("std_r2_rptr_b", rd.rptr_b_out, 2);
    check("std_r2_rptr_g", rd.rptr_g_out, 4'b0011);
    check("std_r2_empty",  rd.empty_out,  0);
    step();
    check("std_r3_rdata",  rd.rdata_out,  8'hA2);
    check("std_r3_rvalid", rd.rvalid_out, 1);
    check("std_r3_rptr_b", rd.rptr_b_out, 3);
    check("std_r3_rptr_g", rd.rptr_g_out, 4'b0010);
    check("std_r3_empty",  rd.empty_out,  1);

    // Underflow: reads while empty are ignored.
    for (int i = 0; i < 4; i++) begin
      step();
      check("unf_rptr",   rd.rptr_b_out, 3);
      check("unf_rvalid", rd.rvalid_out, 0);
    end
    check("unf_rdata", rd.rdata_out, 8'hA2);
    rd.read_in = 1'b0;

    // Advance to pointer 7 (write pointer binary 7), checking almost-empty.
    rd.wptr_g_sync_in = 4'b0100;
    step();
    check("ae_empty",  rd.empty_out,  0);
    check("ae_f4",     rd.aempty_out, 0);
    rd.read_in = 1'b1;
    step();
    check("ae_r3_rdata", rd.rdata_out,  8'hA3);
    check("ae_f3",       rd.aempty_out, 0);
    step();
    check("ae_r4_rdata", rd.rdata_out,  8'hA4);
    check("ae_f2",       rd.aempty_out, 1);
    step();
    check("ae_r5_rdata", rd.rdata_out,  8'hA5);
    check("ae_f1_empty", rd.empty_out,  0);
    step();
    rd.read_in = 1'b0;
    check("ae_r6_rdata", rd.rdata_out,  8'hA6);
    check("ae_f0_empty", rd.empty_out,  1);
    check("ae_rptr7",    rd.rptr_b_out, 7);
    check("wr_raddr7",   rd.raddr_out,  7);
    check("wr_rptr_g7",  rd.rptr_g_out, 4'b0100);

    // Wrap-around: write pointer binary 9.
    mem[0] = 8'hB0;
    mem[1] = 8'hB1;
    rd.wptr_g_sync_in = 4'b1101;
    step();
    check("wr_empty_drop", rd.empty_out, 0);
    rd.read_in = 1'b1;
    step();
    check("wr_r1_rdata",  rd.rdata_out,  8'hA7);
    check("wr_r1_raddr",  rd.raddr_out,  0);
    check("wr_r1_rptr_g", rd.rptr_g_out, 4'b1100);
    check("wr_r1_rptr_b", rd.rptr_b_out, 8);
    check("wr_r1_empty",  rd.empty_out,  0);
    step();
    rd.read_in = 1'b0;
    check("wr_r2_rdata",  rd.rdata_out,  8'hB0);
    check("wr_r2_raddr",  rd.raddr_out,  1);
    check("wr_r2_rptr_g", rd.rptr_g_out, 4'b1101);
    check("wr_r2_empty",  rd.empty_out,  1);

    // One more word (binary 10), then reset mid-cycle with a pop pending.
    rd.wptr_g_sync_in = 4'b1111;
    step();
    rd.read_in = 1'b1;
    step();
    check("pre_rst_rdata",  rd.rdata_out,  8'hB1);
    check("pre_rst_rvalid", rd.rvalid_out, 1);
    check("pre_rst_rptr",   rd.rptr_b_out, 10);
`endif

    // Asynchronous reset pulse in the middle of a clock cycle.
    #2 nrst = 1'b0;
    #1 check_reset("rst1");
    rd.read_in        = 1'b0;
    rd.wptr_g_sync_in = 4'b0000;
    step();
    nrst = 1'b1;
    step();
    check("post_rst_rptr",  rd.rptr_b_out, 0);
    check("post_rst_empty", rd.empty_out,  1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fifo_async_read_ctrl.md
# fifo_async_read_ctrl

Read-side controller of the asynchronous FIFO. It runs entirely in the read clock domain and owns the read pointer, in both binary and Gray form. It takes the write pointer after it has passed through the two-flop synchroniser and derives the empty and almost-empty flags from it. It drives the dual-port RAM read address and registers the read data.

## Interface
Parameters:
- WIDTH, 8, data word width.
- PTR_WIDTH, 4, pointer width including the wrap bit. RAM depth is 2^(PTR_WIDTH-1).
- AEMPTY_LEVEL, 1, `aempty_out` asserts when the fill level is at or below this value.

Ports:
- read_clk  in  1  read-domain clock, rising edge.
- nrst_in  in  1  reset, asynchronous and active-low.
- read_in  in  1  read request / pop.
- wptr_g_sync_in  in  PTR_WIDTH  write pointer, Gray-coded, already synchronised into `read_clk`.
- rdata_mem_in  in  WIDTH  RAM read data; combinational from `raddr_out`.
- raddr_out  out  PTR_WIDTH-1  RAM read address, equal to `rptr_b_out[PTR_WIDTH-2:0]`.
- rptr_b_out  out  PTR_WIDTH  binary read pointer.
- rptr_g_out  out  PTR_WIDTH  Gray read pointer, sent to the write-side synchroniser.
- empty_out  out  1  no word is available to read.
- aempty_out  out  1  fill level is at or below AEMPTY_LEVEL.
- rdata_out  out  WIDTH  registered read data.
- rvalid_out  out  1  `rdata_out` holds valid data.

## Operation
- Accept condition: `accept = read_in & ~mem_empty`, where `mem_empty` is the internal registered empty flag.
- Pointer update:
  - `rptr_b_next = rptr_b_out + accept`, computed modulo 2^PTR_WIDTH.
  - `rptr_g_next = (rptr_b_next >> 1) ^ rptr_b_next`.
  - Both `rptr_b_out` and `rptr_g_out` are registered.
- Empty flag: `mem_empty <= (rptr_g_next == wptr_g_sync_in)`. The comparison is on Gray codes over the full width, wrap bit included.
- Fill level:
  - `wptr_b_sync` is obtained from `wptr_g_sync_in` by Gray-to-binary conversion.
  - `fill = wptr_b_sync - rptr_b_next`, PTR_WIDTH bits, modular.
  - `aempty_out <= (fill <= AEMPTY_LEVEL)`, registered.
  - Fill counts RAM words only.
- Data path (standard mode):
  - On `accept`: `rdata_out <= rdata_mem_in` (the word at the old `raddr_out`), and `rvalid_out <= 1`.
  - Otherwise: `rvalid_out <= 0` and `rdata_out` holds its value.
- `empty_out` equals `mem_empty`.
- A read issued while empty is ignored: pointer, data and flags do not change.
- The address wraps naturally when it passes 2^(PTR_WIDTH-1)-1. The wrap bit toggles at that point.

## Timing
- Reset values, applied asynchronously:
  - `rptr_b_out = 0`, `rptr_g_out = 0`, `raddr_out = 0`.
  - `empty_out = 1`, `aempty_out = 1`.
  - `rdata_out = 0`, `rvalid_out = 0`.
  - All internal state is cleared.
- Reset asserted mid-operation takes effect immediately; any in-flight pop is discarded.
- Reset release is synchronised externally. The first active edge is the first `read_clk` rise with `nrst_in = 1`.
- Standard mode, read latency is 1 cycle:
  - `read_in` is sampled at edge N.
  - `rdata_out` and `rvalid_out` are valid after edge N.
  - The pointer advances at edge N.
- Popping the last word asserts `empty_out` at the same edge the pointer advances. Back-to-back reads therefore never over-read.
- Empty deassert latency: 1 `read_clk` cycle after `wptr_g_sync_in` changes. The synchroniser's own 2 cycles are external to this block.
- Simultaneous pointer arrival and read on the last word: `empty_out` is set from the new comparison, so it stays 0 only if `wptr_g_sync_in` has already moved past `rptr_g_next`.

## Configuration
- Macro: `FIFO_ASYNC_RD_FWFT_EN`.
- Undefined: standard mode as described above.
- Defined: first-word-fall-through mode.
  - The output register holds the head word; `rvalid_out` is high while the head is valid.
  - A prefetch fires when `~mem_empty & (~rvalid_out | read_in)`. It loads `rdata_out`, sets `rvalid_out` and advances the pointer.
  - `read_in` acts as a pop when `rvalid_out = 1`. If it pops and no prefetch fires in the same cycle, `rvalid_out <= 0`.
  - `read_in` with `rvalid_out = 0` is ignored.
  - `empty_out = ~rvalid_out`.
  - Latency from a `wptr_g_sync_in` change to `rvalid_out = 1` is 2 cycles.

## Test plan
All scenarios use PTR_WIDTH=4 (depth 8).

- Reset: pulse `nrst_in` low asynchronously mid-cycle. Outputs clear immediately: `empty_out = 1`, `aempty_out = 1`, pointers `0`, `rvalid_out = 0`, `rdata_out = 0`.
- Standard read:
  - Stimulus: `wptr_g_sync_in = 4'b0010` (binary 3); RAM words A0, A1, A2. One cycle later `empty_out = 0`. Then hold `read_in` for 3 cycles.
  - Response: `rdata_out` = A0, A1, A2 with `rvalid_out = 1`. `rptr_b_out` = 1, 2, 3 and `rptr_g_out` = 0001, 0011, 0010. `empty_out = 1` from the third edge.
- Underflow: hold `read_in = 1` for 4 cycles while empty. Pointer stays at 3, `rvalid_out` stays 0, `rdata_out` holds A2.
- Wrap-around:
  - Stimulus: `rptr_b_out = 7`; `wptr_g_sync_in = 4'b1101` (binary 9). Read 2 words.
  - Response: `raddr_out` goes 7 → 0 → 1. `rptr_g_out` goes 0100 → 1100 → 1101. `empty_out = 1` after the second read.
- Almost-empty: with AEMPTY_LEVEL=2 and fill 3, `aempty_out = 0`. After one read `aempty_out = 1`. After two more reads, `empty_out = 1`.
- FWFT mode (`FIFO_ASYNC_RD_FWFT_EN` defined):
  - Stimulus: `wptr_g_sync_in` moves to 0001 with RAM word D0, no read issued.
  - Response: `rvalid_out = 1` and `rdata_out = D0` two cycles later. A single `read_in` then gives `rvalid_out = 0` and `empty_out = 1` on the next cycle.
